// File: rtl/gate_bist_if.sv
// gate_bist_if: run handshake, result reporting and gate-bank stimulus/response bundle.
interface gate_bist_if;
  logic start, busy, done, pass;
  logic [7:0] err_count;
  logic [6:0] fail_vector;
  logic a, b;
  logic and_out, or_out, nand_out, nor_out, notb_out, xor_out, xnor_out;
  modport master (
    input  start, and_out, or_out, nand_out, nor_out, notb_out, xor_out, xnor_out,
    output busy, done, pass, err_count, fail_vector, a, b
  );
  modport slave (
    output start, and_out, or_out, nand_out, nor_out, notb_out, xor_out, xnor_out,
    input  busy, done, pass, err_count, fail_vector, a, b
  );
endinterface

// File: rtl/gate_bist.sv
// gate_bist: exhaustive 4-vector self-test of the two-input gate bank.
// Define GATE_BIST_FAIL_LOG_EN to add the first-failure capture outputs.
module gate_bist #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned PASSES        = 1
) (
  input  logic        clk,
  input  logic        rst,
  gate_bist_if.master bus
`ifdef GATE_BIST_FAIL_LOG_EN
  ,
  output logic        first_fail_valid,
  output logic [1:0]  first_fail_idx,
  output logic [6:0]  first_fail_syn
`endif
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_e;
  // With no settle time each vector goes straight to its sample cycle.
  localparam state_e ENTRY = (SETTLE_CYCLES == 0) ? SAMPLE : DRIVE;
  state_e state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] sweep_q, sweep_d, err_q, err_d;
  logic [3:0] settle_q, settle_d;
  logic [6:0] fv_q, fv_d, mism;
  logic a_q, a_d, b_q, b_d, pass_q, pass_d;
  assign mism = {a_q & b_q, a_q | b_q, ~(a_q & b_q), ~(a_q | b_q), ~b_q, a_q ^ b_q, ~(a_q ^ b_q)}
              ^ {bus.and_out, bus.or_out, bus.nand_out, bus.nor_out, bus.notb_out, bus.xor_out, bus.xnor_out};
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_d  = sweep_q;
    settle_d = settle_q;
    err_d    = err_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d  = ENTRY;
        idx_d    = 2'd0;
        sweep_d  = 8'd0;
        settle_d = 4'd0;
        err_d    = 8'd0;
        fv_d     = 7'd0;
        pass_d   = 1'b0;
      end
      DRIVE: begin
        settle_d = settle_q + 4'd1;
        state_d  = (settle_q == 4'(SETTLE_CYCLES - 1)) ? SAMPLE : DRIVE;
      end
      SAMPLE: begin
        err_d    = (mism != '0 && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
        fv_d     = fv_q | mism;
        idx_d    = idx_q + 2'd1;
        settle_d = 4'd0;
        sweep_d  = (idx_q == 2'd3) ? sweep_q + 8'd1 : sweep_q;
        state_d  = (idx_q == 2'd3 && sweep_q == 8'(PASSES - 1)) ? DONE : ENTRY;
      end
      DONE: begin
        pass_d  = (err_q == 8'd0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    a_d = (state_d == DRIVE || state_d == SAMPLE) & idx_d[1];
    b_d = (state_d == DRIVE || state_d == SAMPLE) & idx_d[0];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      sweep_q  <= 8'd0;
      settle_q <= 4'd0;
      err_q    <= 8'd0;
      fv_q     <= 7'd0;
      pass_q   <= 1'b0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      settle_q <= settle_d;
      err_q    <= err_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
      a_q      <= a_d;
      b_q      <= b_d;
    end
  end
  assign bus.a           = a_q;
  assign bus.b           = b_q;
  assign bus.busy        = (state_q == DRIVE || state_q == SAMPLE);
  assign bus.done        = (state_q == DONE);
  assign bus.pass        = pass_q;
  assign bus.err_count   = err_q;
  assign bus.fail_vector = fv_q;
`ifdef GATE_BIST_FAIL_LOG_EN
  logic       ffv_q, ffv_d;
  logic [1:0] ffi_q, ffi_d;
  logic [6:0] ffs_q, ffs_d;
  always_comb begin
    ffv_d = ffv_q;
    ffi_d = ffi_q;
    ffs_d = ffs_q;
    if (state_q == IDLE && bus.start) begin
      ffv_d = 1'b0;
      ffi_d = 2'd0;
      ffs_d = 7'd0;
    end else if (state_q == SAMPLE && mism != '0 && !ffv_q) begin
      ffv_d = 1'b1;
      ffi_d = idx_q;
      ffs_d = mism;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ffv_q <= 1'b0;
      ffi_q <= 2'd0;
      ffs_q <= 7'd0;
    end else begin
      ffv_q <= ffv_d;
      ffi_q <= ffi_d;
      ffs_q <= ffs_d;
    end
  end
  assign first_fail_valid = ffv_q;
  assign first_fail_idx   = ffi_q;
  assign first_fail_syn   = ffs_q;
`endif
endmodule
